// File: rtl/cmd_arbiter.sv
// cmd_arbiter: synchronizes the start switch and buttons, latches button events
// as pending requests and serializes them into a valid/ready command stream.
module cmd_arbiter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DROP_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_sw,
   input  logic [4:0]        bd_num_sw,
   input  logic              rst_bt,
   input  logic              rand_bt,
   input  logic [3:0]        act_bt,
   input  logic              cmd_ready,
   output logic              cmd_valid,
   output logic [1:0]        cmd_op,
   output logic [4:0]        cmd_arg,
   output logic              run_led,
   output logic [DROP_W-1:0] drop_cnt
);
   localparam int unsigned NIN   = 7;  // st, clear, rand, act0..act3
   localparam int unsigned NPEND = 6;  // clear, rand, act0..act3
   localparam int unsigned OP_W  = 2;
   localparam int unsigned ARG_W = 5;
   localparam int unsigned IDX_W = 3;

   localparam logic [OP_W-1:0] OP_LOAD  = 2'd0;
   localparam logic [OP_W-1:0] OP_CLEAR = 2'd1;
   localparam logic [OP_W-1:0] OP_RAND  = 2'd2;
   localparam logic [OP_W-1:0] OP_ACT   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
   logic [NIN-1:0]    edge_q;
   logic [NIN-1:0]    sync_last_c;
   logic [NIN-1:0]    evt_c;
   logic [NPEND-1:0]  pend_evt_c;
   logic              st_rise_c;
   logic              st_fall_c;

   state_e            state_q, state_d;
   logic [NPEND-1:0]  pend_q, pend_d;
   logic [ARG_W-1:0]  board_q, board_d;
   logic              valid_q, valid_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [ARG_W-1:0]  arg_q, arg_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic              run_led_q;

   logic [IDX_W-1:0]  gidx_c;
   logic [NPEND-1:0]  drops_c;
   logic [IDX_W-1:0]  ndrop_c;
   logic [DROP_W:0]   sum_c;

   // Synchronizer chains plus rising/falling edge reference register
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= '0;
         edge_q <= '0;
      end else begin
         if (SYNC_STAGES > 1) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {act_bt, rand_bt, rst_bt, st_sw}};
         end else begin
            sync_q <= {act_bt, rand_bt, rst_bt, st_sw};
         end
         edge_q <= sync_last_c;
      end
   end

   assign sync_last_c = sync_q[SYNC_STAGES-1];
   assign evt_c       = sync_last_c & ~edge_q;
   assign pend_evt_c  = evt_c[NIN-1:1];
   assign st_rise_c   = evt_c[0];
   assign st_fall_c   = ~sync_last_c[0] & edge_q[0];

   // Lowest set index wins: CLEAR > RAND > ACT0 > ... > ACT3
   always_comb begin
      gidx_c = '0;
      for (int i = int'(NPEND) - 1; i >= 0; i--) begin
         if (pend_q[i]) gidx_c = IDX_W'(i);
      end
   end

   always_comb begin
      ndrop_c = '0;
      for (int i = 0; i < int'(NPEND); i++) begin
         ndrop_c = ndrop_c + IDX_W'(drops_c[i]);
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      board_d = board_q;
      valid_d = valid_q;
      op_d    = op_q;
      arg_d   = arg_q;
      drop_d  = drop_q;
      drops_c = '0;
      sum_c   = '0;

      if (valid_q && cmd_ready) valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (st_rise_c) begin
               state_d = S_LOAD;
               board_d = bd_num_sw;
            end
         end
         S_LOAD: begin
            // The LOAD offer is placed even if the switch drops, so DRAIN completes it
            if (!valid_q) begin
               valid_d = 1'b1;
               op_d    = OP_LOAD;
               arg_d   = board_q;
            end
            if (st_fall_c) begin
               state_d = S_DRAIN;
            end else if (valid_q && cmd_ready) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (st_fall_c) begin
               state_d = S_DRAIN;
            end else if ((!valid_q || cmd_ready) && (|pend_q)) begin
               valid_d        = 1'b1;
               pend_d[gidx_c] = 1'b0;
               case (gidx_c)
                  3'd0:    begin op_d = OP_CLEAR; arg_d = '0; end
                  3'd1:    begin op_d = OP_RAND;  arg_d = '0; end
                  default: begin op_d = OP_ACT;   arg_d = ARG_W'(gidx_c - 3'd2); end
               endcase
            end
         end
         S_DRAIN: begin
            if (!valid_q || cmd_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_q == S_LOAD || state_q == S_RUN) begin
         drops_c = pend_q & pend_evt_c;
         pend_d  = pend_d | (pend_evt_c & ~pend_q);
         if (pend_evt_c[0]) pend_d[NPEND-1:1] = '0;
         if (st_fall_c) pend_d = '0;
         sum_c = {1'b0, drop_q} + (DROP_W+1)'(ndrop_c);
         drop_d = sum_c[DROP_W] ? '1 : sum_c[DROP_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         pend_q    <= '0;
         board_q   <= '0;
         valid_q   <= 1'b0;
         op_q      <= '0;
         arg_q     <= '0;
         drop_q    <= '0;
         run_led_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         board_q   <= board_d;
         valid_q   <= valid_d;
         op_q      <= op_d;
         arg_q     <= arg_d;
         drop_q    <= drop_d;
         run_led_q <= (state_d == S_RUN);
      end
   end

   assign cmd_valid = valid_q;
   assign cmd_op    = op_q;
   assign cmd_arg   = arg_q;
   assign run_led   = run_led_q;
   assign drop_cnt  = drop_q;

endmodule
